// File: rtl/ft245_cmd_decoder_pkg.sv
// ft245_cmd_decoder_pkg: shared widths, frame length and FSM state encoding for the FT245 command path
package ft245_cmd_decoder_pkg;
    localparam int FT245_WIDTH    = 8;
    localparam int REG_ADDR_WIDTH = FT245_WIDTH;
    localparam int REG_DATA_WIDTH = 2 * FT245_WIDTH;
    localparam int FRAME_LEN      = 3;
    typedef enum logic [1:0] {
        S_ADDR  = 2'd0,
        S_MSB   = 2'd1,
        S_LSB   = 2'd2,
        S_WRITE = 2'd3
    } state_t;
endpackage

// File: rtl/ft245_cmd_decoder_if.sv
// ft245_cmd_decoder_if: FT245 RX byte handshake plus register write bus
interface ft245_cmd_decoder_if;
    import ft245_cmd_decoder_pkg::*;
    logic [FT245_WIDTH-1:0]    rx_data_si;
    logic                      rx_rdy_si;
    logic                      rx_ack_si;
    logic [REG_ADDR_WIDTH-1:0] reg_addr;
    logic [REG_DATA_WIDTH-1:0] reg_data;
    logic                      reg_wr;
    logic                      frame_err;
    modport master (input rx_data_si, rx_rdy_si, output rx_ack_si, reg_addr, reg_data, reg_wr, frame_err);
    modport slave  (output rx_data_si, rx_rdy_si, input rx_ack_si, reg_addr, reg_data, reg_wr, frame_err);
endinterface

// File: rtl/ft245_cmd_decoder_timeout.sv
// cmd_timeout_counter: saturating idle counter that flags expiry after TIMEOUT_CYCLES-1 counted clocks
module cmd_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);
    localparam int W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else if (clear || !run) cnt <= '0;
        else if (cnt != LAST) cnt <= cnt + 1'b1;
    assign expired = run && cnt == LAST;
endmodule

// File: rtl/ft245_cmd_decoder.sv
// ft245_cmd_decoder: assembles {ADDR,MSB,LSB} byte frames from the FT245 RX stream into register writes
// Optional partial-frame timeout enabled by defining CMD_TIMEOUT_EN.
module ft245_cmd_decoder
    import ft245_cmd_decoder_pkg::*;
`ifdef CMD_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 1000000
)
`endif
(
    input logic                 clk,
    input logic                 rst,
    ft245_cmd_decoder_if.master bus
);
    state_t state, state_d;
    logic [FT245_WIDTH-1:0] addr_q, msb_q;
    logic xfer, expired;
    assign bus.rx_ack_si = rst & bus.rx_rdy_si & (state != S_WRITE);
    assign xfer          = bus.rx_ack_si;
    assign bus.reg_wr    = state == S_WRITE;
`ifdef CMD_TIMEOUT_EN
    logic err_q;
    cmd_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (xfer),
        .run     (state == S_MSB || state == S_LSB),
        .expired (expired)
    );
    always_ff @(posedge clk or negedge rst)
        if (!rst) err_q <= 1'b0;
        else err_q <= expired & ~xfer;
    assign bus.frame_err = err_q;
`else
    assign expired       = 1'b0;
    assign bus.frame_err = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= S_ADDR;
        else state <= state_d;
    // encodings are sequential, so a transfer simply advances to the next state
    always_comb begin
        state_d = state == S_WRITE ? S_ADDR :
                  xfer             ? state_t'(state + 2'd1) :
                  expired          ? S_ADDR : state;
    end
    // outputs load on the last-byte edge so they are valid for the whole strobe cycle
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            addr_q       <= '0;
            msb_q        <= '0;
            bus.reg_addr <= '0;
            bus.reg_data <= '0;
        end else if (xfer) begin
            if (state == S_ADDR) addr_q <= bus.rx_data_si;
            if (state == S_MSB) msb_q <= bus.rx_data_si;
            if (state == S_LSB) begin
                bus.reg_addr <= addr_q;
                bus.reg_data <= {msb_q, bus.rx_data_si};
            end
        end
endmodule
